// File: rtl/sips4_exec_core.sv
// SIPS4 execution core: 8x4 register file, 4-bit NZCV ALU, 16x4 data RAM.
// Optional macro SIPS4_R0_ZERO_EN hardwires register 0 to zero.
module sips4_exec_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rf_we,
    input  logic [2:0] rf_ra1,
    input  logic [2:0] rf_ra2,
    input  logic [2:0] rf_wa,
    input  logic [3:0] rf_wd,
    output logic [3:0] rf_rd1,
    output logic [3:0] rf_rd2,
    input  logic [3:0] alu_op,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    output logic [3:0] alu_result,
    output logic [3:0] alu_flags,
    input  logic       ram_we,
    input  logic [3:0] ram_waddr,
    input  logic [3:0] ram_wdata,
    input  logic [3:0] ram_raddr,
    output logic [3:0] ram_rdata
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SAR  = 4'd8,
        OP_PASS = 4'd9,
        OP_INC  = 4'd10,
        OP_DEC  = 4'd11
    } alu_op_e;

    logic [3:0] regs_q [8];
    logic [3:0] mem_q  [16];
    logic       rf_wr_ok;

`ifdef SIPS4_R0_ZERO_EN
    assign rf_wr_ok = rf_we && (rf_wa != 3'd0);
    assign rf_rd1   = (rf_ra1 == 3'd0) ? 4'h0 : regs_q[rf_ra1];
    assign rf_rd2   = (rf_ra2 == 3'd0) ? 4'h0 : regs_q[rf_ra2];
`else
    assign rf_wr_ok = rf_we;
    assign rf_rd1   = regs_q[rf_ra1];
    assign rf_rd2   = regs_q[rf_ra2];
`endif

    assign ram_rdata = mem_q[ram_raddr];

    // Register file storage; reset clears every word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else if (rf_wr_ok) begin
            regs_q[rf_wa] <= rf_wd;
        end
    end

    // Data RAM storage; cleared by reset like the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else if (ram_we) begin
            mem_q[ram_waddr] <= ram_wdata;
        end
    end

    logic [4:0] add_s;
    logic [4:0] sub_s;
    logic [4:0] inc_s;
    logic [4:0] dec_s;

    assign add_s = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub_s = {1'b0, alu_a} - {1'b0, alu_b};
    assign inc_s = {1'b0, alu_a} + 5'd1;
    assign dec_s = {1'b0, alu_a} - 5'd1;

    logic [3:0] res;
    logic       c_f;
    logic       v_f;
    logic       rsvd;

    // Combinational ALU; bit 4 of each sum is carry out (or borrow).
    always_comb begin
        res  = 4'h0;
        c_f  = 1'b0;
        v_f  = 1'b0;
        rsvd = 1'b0;
        case (alu_op)
            OP_ADD: begin
                res = add_s[3:0];
                c_f = add_s[4];
                v_f = (alu_a[3] == alu_b[3]) && (res[3] != alu_a[3]);
            end
            OP_SUB: begin
                res = sub_s[3:0];
                c_f = sub_s[4];
                v_f = (alu_a[3] != alu_b[3]) && (res[3] != alu_a[3]);
            end
            OP_AND:  res = alu_a & alu_b;
            OP_OR:   res = alu_a | alu_b;
            OP_XOR:  res = alu_a ^ alu_b;
            OP_NOT:  res = ~alu_a;
            OP_SHL: begin
                res = {alu_a[2:0], 1'b0};
                c_f = alu_a[3];
            end
            OP_SHR: begin
                res = {1'b0, alu_a[3:1]};
                c_f = alu_a[0];
            end
            OP_SAR: begin
                res = {alu_a[3], alu_a[3:1]};
                c_f = alu_a[0];
            end
            OP_PASS: res = alu_b;
            OP_INC: begin
                res = inc_s[3:0];
                c_f = inc_s[4];
                v_f = !alu_a[3] && res[3];
            end
            OP_DEC: begin
                res = dec_s[3:0];
                c_f = dec_s[4];
                v_f = alu_a[3] && !res[3];
            end
            default: rsvd = 1'b1;
        endcase
    end

    assign alu_result = res;
    assign alu_flags  = rsvd ? 4'b0100
                             : {res[3], (res == 4'h0), c_f, v_f};

endmodule

// File: tb/tb_sips4_exec_core.sv
// Directed self-checking bench for sips4_exec_core.
// Inputs change on negedge; outputs are checked before or #1 after posedge.
module tb_sips4_exec_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rf_we;
    logic [2:0] rf_ra1, rf_ra2, rf_wa;
    logic [3:0] rf_wd, rf_rd1, rf_rd2;
    logic [3:0] alu_op, alu_a, alu_b, alu_result, alu_flags;
    logic       ram_we;
    logic [3:0] ram_waddr, ram_wdata, ram_raddr, ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sips4_exec_core dut (
        .clk(clk), .rst_n(rst_n),
        .rf_we(rf_we), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_raddr(ram_raddr),
        .ram_rdata(ram_rdata)
    );

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        rf_we = 1'b1; rf_wa = a; rf_wd = d;
        edge_step();
        @(negedge clk);
        rf_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rf_we = 1'b1; rf_wa = 3'd4; rf_wd = 4'hB;
        ram_we = 1'b1; ram_waddr = 4'd2; ram_wdata = 4'hB;
        edge_step();
        @(negedge clk);
        rf_ra1 = 3'd4; ram_raddr = 4'd2;
        #1;
        checks++;
        if (rf_rd1 !== 4'h0) begin
            errors++;
            $display("FAIL reset_rf_write_ignored got %h want 0", rf_rd1);
        end
        checks++;
        if (ram_rdata !== 4'h0) begin
            errors++;
            $display("FAIL reset_ram_write_ignored got %h want 0", ram_rdata);
        end
        rf_we = 1'b0; ram_we = 1'b0;
        rst_n = 1'b1;
        // write r3 and mem[5], then pulse reset mid-cycle
        @(negedge clk);
        rf_we = 1'b1; rf_wa = 3'd3; rf_wd = 4'hA;
        ram_we = 1'b1; ram_waddr = 4'd5; ram_wdata = 4'hA;
        edge_step();
        rf_we = 1'b0; ram_we = 1'b0;
        rf_ra1 = 3'd3; ram_raddr = 4'd5;
        #1;
        checks++;
        if (rf_rd1 !== 4'hA) begin
            errors++;
            $display("FAIL pre_reset_r3 got %h want a", rf_rd1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_rd1 !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_r3 got %h want 0", rf_rd1);
        end
        checks++;
        if (ram_rdata !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_mem5 got %h want 0", ram_rdata);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_regfile();
        rf_write(3'd2, 4'h7);
        rf_write(3'd5, 4'hC);
        rf_ra1 = 3'd2; rf_ra2 = 3'd5;
        #1;
        checks++;
        if (rf_rd1 !== 4'h7) begin
            errors++;
            $display("FAIL rf_rd1_r2 got %h want 7", rf_rd1);
        end
        checks++;
        if (rf_rd2 !== 4'hC) begin
            errors++;
            $display("FAIL rf_rd2_r5 got %h want c", rf_rd2);
        end
        rf_ra2 = 3'd2;
        #1;
        checks++;
        if (rf_rd2 !== 4'h7) begin
            errors++;
            $display("FAIL rf_same_addr_both got %h want 7", rf_rd2);
        end
        @(negedge clk);
        rf_we = 1'b1; rf_wa = 3'd2; rf_wd = 4'h1;
        #1;
        checks++;
        if (rf_rd1 !== 4'h7) begin
            errors++;
            $display("FAIL rf_rdw_before_edge got %h want 7", rf_rd1);
        end
        edge_step();
        rf_we = 1'b0;
        checks++;
        if (rf_rd1 !== 4'h1) begin
            errors++;
            $display("FAIL rf_rdw_after_edge got %h want 1", rf_rd1);
        end
        rf_ra1 = 3'd5;
        #1;
        checks++;
        if (rf_rd1 !== 4'hC) begin
            errors++;
            $display("FAIL rf_r5_untouched got %h want c", rf_rd1);
        end
    endtask

    task automatic test_alu();
        logic [3:0] op_t  [17] = '{0,0,1,1,2,3,4,5,6,7,8,8,9,10,11,13,12};
        logic [3:0] a_t   [17] = '{7,15,3,8,12,5,6,5,9,9,8,9,15,15,0,15,3};
        logic [3:0] b_t   [17] = '{1,1,5,1,10,10,6,0,0,0,0,0,3,0,0,15,4};
        logic [3:0] r_t   [17] = '{8,0,14,7,8,15,0,10,2,4,12,12,3,0,15,0,0};
        logic [3:0] f_t   [17] = '{4'b1001,4'b0110,4'b1010,4'b0001,
                                   4'b1000,4'b1000,4'b0100,4'b1000,
                                   4'b0010,4'b0010,4'b1000,4'b1010,
                                   4'b0000,4'b0110,4'b1010,4'b0100,
                                   4'b0100};
        for (int i = 0; i < 17; i++) begin
            alu_op = op_t[i]; alu_a = a_t[i]; alu_b = b_t[i];
            #1;
            checks++;
            if (alu_result !== r_t[i] || alu_flags !== f_t[i]) begin
                errors++;
                $display("FAIL alu_vec%0d op=%0d a=%h b=%h got %h/%b want %h/%b",
                         i, alu_op, alu_a, alu_b, alu_result, alu_flags,
                         r_t[i], f_t[i]);
            end
        end
    endtask

    task automatic test_ram();
        @(negedge clk);
        ram_we = 1'b1; ram_waddr = 4'hF; ram_wdata = 4'h6; ram_raddr = 4'hF;
        edge_step();
        ram_we = 1'b0;
        checks++;
        if (ram_rdata !== 4'h6) begin
            errors++;
            $display("FAIL ram_write_f got %h want 6", ram_rdata);
        end
        @(negedge clk);
        ram_wdata = 4'h9;
        edge_step();
        checks++;
        if (ram_rdata !== 4'h6) begin
            errors++;
            $display("FAIL ram_we_low_hold got %h want 6", ram_rdata);
        end
        ram_raddr = 4'h5;
        #1;
        checks++;
        if (ram_rdata !== 4'h0) begin
            errors++;
            $display("FAIL ram_other_addr got %h want 0", ram_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        rf_we = 1'b1; rf_wa = 3'd6; rf_wd = 4'h3;
        ram_we = 1'b1; ram_waddr = 4'h1; ram_wdata = 4'hD;
        rf_ra1 = 3'd6; ram_raddr = 4'h1;
        edge_step();
        rf_we = 1'b0; ram_we = 1'b0;
        checks++;
        if (rf_rd1 !== 4'h3 || ram_rdata !== 4'hD) begin
            errors++;
            $display("FAIL simul_write got rf=%h ram=%h want 3/d",
                     rf_rd1, ram_rdata);
        end
    endtask

    task automatic test_r0();
        rf_write(3'd0, 4'h5);
        rf_ra1 = 3'd0; rf_ra2 = 3'd0;
        #1;
        checks++;
`ifdef SIPS4_R0_ZERO_EN
        if (rf_rd1 !== 4'h0 || rf_rd2 !== 4'h0) begin
            errors++;
            $display("FAIL r0_hardwired got %h/%h want 0", rf_rd1, rf_rd2);
        end
`else
        if (rf_rd1 !== 4'h5 || rf_rd2 !== 4'h5) begin
            errors++;
            $display("FAIL r0_storage got %h/%h want 5", rf_rd1, rf_rd2);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        rf_we = 1'b0; rf_ra1 = '0; rf_ra2 = '0; rf_wa = '0; rf_wd = '0;
        alu_op = '0; alu_a = '0; alu_b = '0;
        ram_we = 1'b0; ram_waddr = '0; ram_wdata = '0; ram_raddr = '0;
        test_reset();
        test_regfile();
        test_alu();
        test_ram();
        test_back_to_back();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
